ram_burst_reader: RTL and testbench

- Upstream neighbour of the FIFO-fill stage.
- Accepts one burst request (start address, word count) from the FIFO-fill stage.
- Issues sequential reads to the frame RAM and returns the words as a dvalid/dlast stream.
- One request in flight at a time. No downstream backpressure: the consumer always accepts.

---
 rtl/rd_burst_pkg.sv | 20 ++
 rtl/rd_lat_pipe.sv | 48 ++++
 rtl/ram_burst_reader.sv | 130 +++++++++++++
 tb/tb_ram_burst_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_burst_pkg.sv
// Shared types and constants for the frame-RAM burst reader and its latency pipe.
package rd_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic last;
  } pipe_tag_t;

  localparam int TAG_W = $bits(pipe_tag_t);

endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep {valid,last} shift register aligned to the RAM read latency, with the
// stream data word taken from the RAM at the output stage and held between beats.
module rd_lat_pipe
  import rd_burst_pkg::*;
#(
  parameter int DEPTH          = 1,
  parameter int DW             = 24,
  parameter bit EMPTY_INCL_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] ram_data,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  output logic          empty
);

  pipe_tag_t     tag_q [DEPTH];
  logic [DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      data_q <= '0;
    end else begin
      tag_q[0] <= '{valid: in_valid, last: in_valid & in_last};
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      if (tag_q[DEPTH-1].valid) data_q <= ram_data;
    end
  end

  // The RAM itself supplies the delay, so its data lines up with the final tag stage.
  assign out_valid = tag_q[DEPTH-1].valid;
  assign out_last  = tag_q[DEPTH-1].last;
  assign out_data  = tag_q[DEPTH-1].valid ? ram_data : data_q;

  // Without EMPTY_INCL_OUT, a beat at the output stage leaves this cycle and is not counted.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_q[i].valid && (EMPTY_INCL_OUT || (i != DEPTH-1))) empty = 1'b0;
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst reader: turns one {start, count} request into sequential frame-RAM reads and a
// dvalid/dlast stream. Define BURST_OUT_REG_EN to add one register stage on the stream.
//
// state | meaning
// IDLE  | waiting for ren
// ISSUE | one RAM read per cycle until the last beat is tagged
// DRAIN | waiting for outstanding reads to leave the stream
// DONE  | rdone pulse, back to IDLE
module ram_burst_reader
  import rd_burst_pkg::*;
#(
  parameter int RAM_AW       = 8,
  parameter int I_DATA_WIDTH = 24,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ren,
  input  logic [RAM_AW-1:0]       raddr,
  input  logic [RAM_AW-1:0]       rlength,
  output logic                    busy,
  output logic                    ram_en,
  output logic [RAM_AW-1:0]       ram_addr,
  input  logic [I_DATA_WIDTH-1:0] ram_dout,
  output logic                    dvalid,
  output logic                    dlast,
  output logic [I_DATA_WIDTH-1:0] dout,
  output logic                    rdone,
  output logic                    req_err
);

  localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam logic [RAM_AW-1:0] ONE = RAM_AW'(1);

`ifdef BURST_OUT_REG_EN
  localparam bit EMPTY_INCL_OUT = 1'b1;
`else
  localparam bit EMPTY_INCL_OUT = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [RAM_AW-1:0]       addr_cnt;
  logic [RAM_AW-1:0]       rem;
  logic                    issue_last;
  logic                    pipe_valid, pipe_last, pipe_empty;
  logic [I_DATA_WIDTH-1:0] pipe_data;

  assign issue_last = (state_q == ISSUE) && (rem == ONE);
  assign ram_addr   = addr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_cnt <= '0;
      rem      <= '0;
      req_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && ren && (rlength != '0)) begin
        addr_cnt <= raddr;
        rem      <= rlength;
      end else if (state_q == ISSUE) begin
        rem <= rem - ONE;
        // Stop on the last beat so ram_addr keeps showing the final address.
        if (!issue_last) addr_cnt <= addr_cnt + ONE;
      end
      if ((state_q != IDLE) && ren) req_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    ram_en  = 1'b0;
    rdone   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (ren) state_d = (rlength == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        ram_en = 1'b1;
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) state_d = DONE;
      end
      DONE: begin
        rdone   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rd_lat_pipe #(
    .DEPTH         (LAT),
    .DW            (I_DATA_WIDTH),
    .EMPTY_INCL_OUT(EMPTY_INCL_OUT)
  ) u_pipe (
    .clk      (clk),
    .clr_n    (rst_n),
    .in_valid (ram_en),
    .in_last  (issue_last),
    .ram_data (ram_dout),
    .out_valid(pipe_valid),
    .out_last (pipe_last),
    .out_data (pipe_data),
    .empty    (pipe_empty)
  );

`ifdef BURST_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvalid <= 1'b0;
      dlast  <= 1'b0;
      dout   <= '0;
    end else begin
      dvalid <= pipe_valid;
      dlast  <= pipe_last;
      if (pipe_valid) dout <= pipe_data;
    end
  end
`else
  assign dvalid = pipe_valid;
  assign dlast  = pipe_last;
  assign dout   = pipe_data;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench: two readers (RD_LAT=1 and RD_LAT=3) on shared requests, each checked every
// cycle against a slot-scheduled model of the burst rules, plus literal spot checks.
module tb_ram_burst_reader;

`ifdef BURST_OUT_REG_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif
  localparam int MAXS = 8192;
  localparam int INF  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n, ren;
  logic [7:0]  raddr, rlength;

  logic        busy0, ram_en0, dvalid0, dlast0, rdone0, req_err0;
  logic [7:0]  ram_addr0;
  logic [23:0] ram_dout0, dout0;
  logic        busy1, ram_en1, dvalid1, dlast1, rdone1, req_err1;
  logic [7:0]  ram_addr1;
  logic [23:0] ram_dout1, dout1;

  always #5 clk = ~clk;

  ram_burst_reader #(.RAM_AW(8), .I_DATA_WIDTH(24), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rlength(rlength),
    .busy(busy0), .ram_en(ram_en0), .ram_addr(ram_addr0), .ram_dout(ram_dout0),
    .dvalid(dvalid0), .dlast(dlast0), .dout(dout0), .rdone(rdone0), .req_err(req_err0));

  ram_burst_reader #(.RAM_AW(8), .I_DATA_WIDTH(24), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rlength(rlength),
    .busy(busy1), .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_dout(ram_dout1),
    .dvalid(dvalid1), .dlast(dlast1), .dout(dout1), .rdone(rdone1), .req_err(req_err1));

  // Frame RAM: data for the address read in slot t appears on ram_dout in slot t+RD_LAT.
  logic [23:0] mem [256];
  logic [23:0] rp0 [4];
  logic [23:0] rp1 [4];
  always @(posedge clk) begin
    for (int j = 3; j > 0; j--) begin
      rp0[j] <= rp0[j-1];
      rp1[j] <= rp1[j-1];
    end
    rp0[0] <= ram_en0 ? mem[ram_addr0] : 24'($urandom);
    rp1[0] <= ram_en1 ? mem[ram_addr1] : 24'($urandom);
  end
  assign ram_dout0 = rp0[0];
  assign ram_dout1 = rp1[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s u%0d at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Model: slot s is the clock period after posedge number s.
  int cyc = 0;
  int lat [2] = '{1 + X, 3 + X};
  int busy_until [2] = '{-1, -1};
  int err_from [2] = '{INF, INF};
  bit exp_rst [2][MAXS];
  bit exp_en [2][MAXS];
  bit exp_dv [2][MAXS];
  bit exp_last [2][MAXS];
  bit exp_done [2][MAXS];
  bit exp_busy [2][MAXS];
  bit [7:0]  exp_addr [2][MAXS];
  bit [23:0] exp_data [2][MAXS];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int c = cyc; c < MAXS; c++) begin
          exp_en[i][c] = 0; exp_dv[i][c] = 0; exp_last[i][c] = 0;
          exp_done[i][c] = 0; exp_busy[i][c] = 0;
        end
        exp_rst[i][cyc] = 1;
        busy_until[i] = -1;
        err_from[i] = INF;
      end else if (ren) begin
        if (cyc - 1 <= busy_until[i]) begin
          if (err_from[i] > cyc) err_from[i] = cyc;
        end else begin
          int len, d;
          len = int'(rlength);
          d = (len == 0) ? cyc : cyc + lat[i] + len;
          for (int k = 0; k < len; k++) begin
            if (cyc + k < MAXS) begin
              exp_en[i][cyc+k] = 1;
              exp_addr[i][cyc+k] = 8'(int'(raddr) + k);
            end
            if (cyc + lat[i] + k < MAXS) begin
              exp_dv[i][cyc+lat[i]+k] = 1;
              exp_data[i][cyc+lat[i]+k] = mem[8'(int'(raddr) + k)];
              exp_last[i][cyc+lat[i]+k] = (k == len - 1);
            end
          end
          for (int c = cyc; c <= d && c < MAXS; c++) exp_busy[i][c] = 1;
          if (d < MAXS) exp_done[i][d] = 1;
          busy_until[i] = d;
        end
      end
    end
  end

  bit chk_on = 0;
  logic [7:0]  hold_addr [2] = '{8'h0, 8'h0};
  logic [23:0] hold_dout [2] = '{24'h0, 24'h0};

  task automatic check_inst(input int i, input logic b, input logic en, input logic [7:0] a,
                            input logic dv, input logic dl, input logic [23:0] d,
                            input logic rd, input logic er);
    int s;
    s = cyc;
    if (exp_rst[i][s]) begin hold_addr[i] = 0; hold_dout[i] = 0; end
    if (exp_en[i][s]) hold_addr[i] = exp_addr[i][s];
    if (exp_dv[i][s]) hold_dout[i] = exp_data[i][s];
    cmp("busy", i, 32'(b), 32'(exp_busy[i][s]));
    cmp("ram_en", i, 32'(en), 32'(exp_en[i][s]));
    cmp("ram_addr", i, 32'(a), 32'(hold_addr[i]));
    cmp("dvalid", i, 32'(dv), 32'(exp_dv[i][s]));
    cmp("dlast", i, 32'(dl), 32'(exp_last[i][s]));
    cmp("dout", i, 32'(d), 32'(hold_dout[i]));
    cmp("rdone", i, 32'(rd), 32'(exp_done[i][s]));
    cmp("req_err", i, 32'(er), 32'(s >= err_from[i]));
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXS) begin
      check_inst(0, busy0, ram_en0, ram_addr0, dvalid0, dlast0, dout0, rdone0, req_err0);
      check_inst(1, busy1, ram_en1, ram_addr1, dvalid1, dlast1, dout1, rdone1, req_err1);
    end
  end

  task automatic request(input logic [7:0] a, input logic [7:0] l);
    ren = 1'b1; raddr = a; rlength = l;
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic goto(input int s);
    while (cyc < s) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cyc > busy_until[0] && cyc > busy_until[1])) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        break;
      end
    end
  endtask

  initial begin
    int e;
    for (int j = 0; j < 256; j++) mem[j] = 24'($urandom);
    rst_n = 1'b0; ren = 1'b0; raddr = 8'h0; rlength = 8'h0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    cmp("rst_busy", 0, 32'(busy0), 0);
    cmp("rst_addr", 0, 32'(ram_addr0), 0);
    cmp("rst_dout", 1, 32'(dout1), 0);
    cmp("rst_err", 1, 32'(req_err1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 words from 0x10
    request(8'h10, 8'd4); e = cyc;
    cmp("b1_en", 0, 32'(ram_en0), 1);
    cmp("b1_addr0", 0, 32'(ram_addr0), 32'h10);
    goto(e + 1 + X);
    cmp("b1_dv", 0, 32'(dvalid0), 1);
    cmp("b1_dout0", 0, 32'(dout0), 32'(mem[8'h10]));
    goto(e + 3);
    cmp("b1_addr3", 0, 32'(ram_addr0), 32'h13);
    goto(e + 4 + X);
    cmp("b1_dlast", 0, 32'(dlast0), 1);
    goto(e + 5 + X);
    cmp("b1_rdone", 0, 32'(rdone0), 1);
    wait_idle();

    // wrap across FF->00
    request(8'hFE, 8'd4); e = cyc;
    goto(e + 2);
    cmp("wrap_addr", 0, 32'(ram_addr0), 32'h00);
    goto(e + 3 + X);
    cmp("wrap_dout", 0, 32'(dout0), 32'(mem[8'h00]));
    wait_idle();

    request(8'h33, 8'd1); e = cyc;
    goto(e + 1 + X);
    cmp("one_dv", 0, 32'(dvalid0 & dlast0), 1);
    goto(e + 2 + X);
    cmp("one_rdone", 0, 32'(rdone0), 1);
    wait_idle();

    request(8'h55, 8'd0); e = cyc;
    cmp("zero_rdone", 0, 32'(rdone0), 1);
    cmp("zero_busy", 0, 32'(busy0), 1);
    cmp("zero_en", 0, 32'(ram_en0), 0);
    @(negedge clk);
    cmp("zero_busy_drop", 0, 32'(busy0), 0);
    wait_idle();

    // RD_LAT=3 instance, 5 words
    request(8'h60, 8'd5); e = cyc;
    goto(e + 2 + X);
    cmp("l3_dv_early", 1, 32'(dvalid1), 0);
    goto(e + 3 + X);
    cmp("l3_dv_first", 1, 32'(dvalid1), 1);
    cmp("l3_dout", 1, 32'(dout1), 32'(mem[8'h60]));
    goto(e + 7 + X);
    cmp("l3_dlast", 1, 32'(dlast1), 1);
    goto(e + 8 + X);
    cmp("l3_rdone", 1, 32'(rdone1), 1);
    wait_idle();

    for (int b = 0; b < 40; b++) begin
      int len;
      len = (b % 13 == 5) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 24));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      request(8'($urandom), 8'(len));
      wait_idle();
    end

    // second request while busy
    request(8'h20, 8'd8); e = cyc;
    goto(e + 2);
    cmp("col_err_before", 0, 32'(req_err0), 0);
    ren = 1'b1; raddr = 8'h99; rlength = 8'd3;
    @(negedge clk);
    ren = 1'b0;
    cmp("col_err", 0, 32'(req_err0), 1);
    wait_idle();
    repeat (2) @(negedge clk);
    cmp("col_err_sticky", 0, 32'(req_err0), 1);

    // reset in the middle of a burst
    request(8'h80, 8'd8); e = cyc;
    goto(e + 2);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("mid_rst_busy", 0, 32'(busy0), 0);
    cmp("mid_rst_dv", 0, 32'(dvalid0), 0);
    cmp("mid_rst_addr", 0, 32'(ram_addr0), 0);
    cmp("mid_rst_err", 0, 32'(req_err0), 0);
    cmp("mid_rst_busy", 1, 32'(busy1), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    request(8'h40, 8'd2); e = cyc;
    goto(e + 1 + X);
    cmp("post_rst_dout", 0, 32'(dout0), 32'(mem[8'h40]));
    goto(e + 2 + X);
    cmp("post_rst_dlast", 0, 32'(dlast0), 1);
    wait_idle();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
